// File: rtl/demux_12_striper.sv
// demux_12_striper: 1:2 demultiplexer/striper.
//
// Consecutive valid input words are steered alternately to lane 0 and lane 1,
// starting at lane 0. All outputs are registered, so there is one cycle of latency.
// A saturating counter accumulates bit transitions on the lane data registers.
//
// Ports:
//   clk           rising-edge clock
//   Reset         synchronous, active-high reset
//   data_in       input word, sampled when valid_in=1
//   valid_in      data_in carries a word this cycle
//   data_out0     lane 0 data register
//   valid_out0    one-cycle pulse: data_out0 was written at the last edge
//   data_out1     lane 1 data register
//   valid_out1    one-cycle pulse: data_out1 was written at the last edge
//   next_lane     lane that receives the next valid word
//   toggle_count  accumulated bit transitions on data_out0/1, saturating
module demux_12_striper #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic [WIDTH-1:0] data_out0,
   output logic             valid_out0,
   output logic [WIDTH-1:0] data_out1,
   output logic             valid_out1,
   output logic             next_lane,
   output logic [CNT_W-1:0] toggle_count
);

   localparam int unsigned PopW = $clog2(WIDTH + 1);

   typedef enum logic {
      StLane0 = 1'b0,
      StLane1 = 1'b1
   } lane_e;

   lane_e            state_q, state_d;
   logic [WIDTH-1:0] data0_q, data0_d;
   logic [WIDTH-1:0] data1_q, data1_d;
   logic             valid0_q, valid0_d;
   logic             valid1_q, valid1_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] diff;
   logic [PopW-1:0]  pop;
   logic [CNT_W:0]   sum;

   always_comb begin
      state_d  = state_q;
      data0_d  = data0_q;
      data1_d  = data1_q;
      valid0_d = 1'b0;
      valid1_d = 1'b0;
      diff     = '0;
      if (valid_in) begin
         unique case (state_q)
            StLane0: begin
               data0_d  = data_in;
               valid0_d = 1'b1;
               diff     = data0_q ^ data_in;
               state_d  = StLane1;
            end
            StLane1: begin
               data1_d  = data_in;
               valid1_d = 1'b1;
               diff     = data1_q ^ data_in;
               state_d  = StLane0;
            end
         endcase
      end

      pop = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         pop = pop + PopW'(diff[i]);
      end

      // Extra carry bit flags overflow; a single step never exceeds the
      // maximum by more than WIDTH, so clamping to all-ones is exact.
      sum   = {1'b0, cnt_q} + (CNT_W + 1)'(pop);
      cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q  <= StLane0;
         data0_q  <= '0;
         data1_q  <= '0;
         valid0_q <= 1'b0;
         valid1_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         data0_q  <= data0_d;
         data1_q  <= data1_d;
         valid0_q <= valid0_d;
         valid1_q <= valid1_d;
         cnt_q    <= cnt_d;
      end
   end

   assign data_out0    = data0_q;
   assign valid_out0   = valid0_q;
   assign data_out1    = data1_q;
   assign valid_out1   = valid1_q;
   assign next_lane    = logic'(state_q);
   assign toggle_count = cnt_q;

endmodule

// File: tb/tb_demux_12_striper.sv
// Self-checking bench for demux_12_striper: directed scenarios plus random
// traffic compared against a behavioural model of lanes and counters.
// A second instance with a 4-bit counter exercises saturation quickly.
module tb_demux_12_striper;

   logic       clk = 1'b0;
   logic       Reset;
   logic [7:0] data_in;
   logic       valid_in;

   logic [7:0]  data_out0, data_out1;
   logic        valid_out0, valid_out1, next_lane;
   logic [15:0] toggle_count;

   logic [7:0] s_data_out0, s_data_out1;
   logic       s_valid_out0, s_valid_out1, s_next_lane;
   logic [3:0] s_toggle_count;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Reference model state
   logic [7:0]  m_data [2];
   logic        m_valid[2];
   int unsigned m_next;
   int unsigned m_cnt16;
   int unsigned m_cnt4;

   always #5 clk = ~clk;

   demux_12_striper #(.WIDTH(8), .CNT_W(16)) dut (
      .clk          (clk),
      .Reset        (Reset),
      .data_in      (data_in),
      .valid_in     (valid_in),
      .data_out0    (data_out0),
      .valid_out0   (valid_out0),
      .data_out1    (data_out1),
      .valid_out1   (valid_out1),
      .next_lane    (next_lane),
      .toggle_count (toggle_count)
   );

   demux_12_striper #(.WIDTH(8), .CNT_W(4)) dut_sat (
      .clk          (clk),
      .Reset        (Reset),
      .data_in      (data_in),
      .valid_in     (valid_in),
      .data_out0    (s_data_out0),
      .valid_out0   (s_valid_out0),
      .data_out1    (s_data_out1),
      .valid_out1   (s_valid_out1),
      .next_lane    (s_next_lane),
      .toggle_count (s_toggle_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input logic rst, input logic v, input logic [7:0] d);
      int unsigned pop;
      if (rst) begin
         m_data[0] = '0; m_data[1] = '0;
         m_valid[0] = 0; m_valid[1] = 0;
         m_next = 0; m_cnt16 = 0; m_cnt4 = 0;
      end else begin
         m_valid[0] = 0; m_valid[1] = 0;
         if (v) begin
            pop = $countones(m_data[m_next] ^ d);
            m_cnt16 = (m_cnt16 + pop > 65535) ? 65535 : m_cnt16 + pop;
            m_cnt4  = (m_cnt4 + pop > 15) ? 15 : m_cnt4 + pop;
            m_data[m_next]  = d;
            m_valid[m_next] = 1;
            m_next = 1 - m_next;
         end
      end
   endtask

   task automatic compare_all();
      check("data_out0",    32'(data_out0),      32'(m_data[0]));
      check("data_out1",    32'(data_out1),      32'(m_data[1]));
      check("valid_out0",   32'(valid_out0),     32'(m_valid[0]));
      check("valid_out1",   32'(valid_out1),     32'(m_valid[1]));
      check("next_lane",    32'(next_lane),      m_next);
      check("toggle_count", 32'(toggle_count),   m_cnt16);
      check("sat_count",    32'(s_toggle_count), m_cnt4);
   endtask

   // Drive one cycle, advance the model at the edge, compare just after it.
   task automatic step(input logic rst, input logic v, input logic [7:0] d);
      Reset    = rst;
      valid_in = v;
      data_in  = d;
      @(posedge clk);
      model_step(rst, v, d);
      #1;
      compare_all();
   endtask

   initial begin
      m_data[0] = '0; m_data[1] = '0;
      m_valid[0] = 0; m_valid[1] = 0;
      m_next = 0; m_cnt16 = 0; m_cnt4 = 0;
      Reset = 1'b1; valid_in = 1'b0; data_in = '0;
      @(negedge clk);

      // Reset overrides a valid word
      step(1, 1, 8'hFF);
      step(1, 1, 8'hFF);
      check("reset_count_const", 32'(toggle_count), 32'd0);

      // Back-to-back stream
      step(0, 1, 8'hA5);
      step(0, 1, 8'h3C);
      step(0, 1, 8'hF0);
      step(0, 1, 8'h0F);
      check("stream_count_16", 32'(toggle_count), 32'd16);
      step(0, 0, 8'h77);

      // Gaps keep parity
      step(1, 0, 8'h00);
      step(0, 1, 8'hA5);
      for (int i = 0; i < 3; i++) step(0, 0, 8'($urandom));
      step(0, 1, 8'h3C);
      check("gap_lane1", 32'(data_out1), 32'h3C);

      // Mid-stream reset restarts lane parity and the counter
      step(1, 0, 8'h00);
      step(0, 1, 8'hA5);
      step(1, 0, 8'h00);
      step(0, 1, 8'h3C);
      check("midreset_lane0", 32'(data_out0), 32'h3C);
      check("midreset_count", 32'(toggle_count), 32'd4);

      // Identical rewrites add nothing
      step(1, 0, 8'h00);
      for (int i = 0; i < 4; i++) step(0, 1, 8'h55);
      step(0, 0, 8'h00);

      // Random traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
      end

      // Drive the 16-bit counter into saturation: FF,FF,00,00 adds 8 per word
      step(1, 0, 8'h00);
      for (int i = 0; i < 8250; i++) begin
         step(0, 1, ((i / 2) % 2 == 0) ? 8'hFF : 8'h00);
      end
      check("sat16_final", 32'(toggle_count), 32'd65535);
      for (int i = 0; i < 10; i++) step(0, 1, 8'($urandom));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
